uart_tx_sequencer: RTL

Transmit-side controller that sequences the baud/bit timing unit (start/BTU/done handshake) and configures its rate for each frame. It accepts a byte plus a frame configuration from the host, builds an 11-bit serial frame, and shifts it out on every BTU. It sits between the host write port and the TX pin of the UART top level.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/tx_frame_builder.sv | 28 ++
 rtl/uart_tx_sequencer.sv | 104 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and the parity helper for the UART transmit path.
package uart_pkg;

    // Bits per serial frame; must match the timing unit's done count.
    localparam int unsigned FRAME_LEN = 11;

    // Level of the TX line when nothing is being sent.
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDrain
    } state_t;

    // XOR of the active data bits, inverted for odd parity.
    function automatic logic tx_parity(logic [7:0] din, logic eight, logic ohel);
        logic [7:0] mask;
        mask = eight ? 8'hFF : 8'h7F;
        return (^(din & mask)) ^ ohel;
    endfunction

endpackage

// File: rtl/tx_frame_builder.sv
// Combinational assembly of one 11-bit serial frame, bit 0 is sent first.
module tx_frame_builder
    import uart_pkg::*;
(
    input  logic [7:0]           din_i,
    input  logic                 eight_i,
    input  logic                 pen_i,
    input  logic                 ohel_i,
    output logic [FRAME_LEN-1:0] frame_o
);

    logic par;
    logic par_or_stop;

    assign par         = tx_parity(din_i, eight_i, ohel_i);
    assign par_or_stop = pen_i ? par : IDLE_LEVEL;

    // Start bit, seven data bits, then data/parity/stop slots depending on length.
    always_comb begin
        frame_o     = '0;
        frame_o[0]  = 1'b0;
        frame_o[7:1] = din_i[6:0];
        frame_o[8]  = eight_i ? din_i[7] : par_or_stop;
        frame_o[9]  = eight_i ? par_or_stop : IDLE_LEVEL;
        frame_o[10] = IDLE_LEVEL;
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Transmit sequencer: accepts a byte, drives the timing unit handshake and
// shifts the frame out one bit per BTU.
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter logic [3:0] RST_BAUD = 4'b0000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [7:0] din_i,
    input  logic       eight_i,
    input  logic       pen_i,
    input  logic       ohel_i,
    input  logic [3:0] baud_sel_i,
    input  logic       btu_i,
    input  logic       done_i,
    output logic       start_o,
    output logic [3:0] baud_val_o,
    output logic       tx_o,
    output logic       txrdy_o,
    output logic       load_err_o
);

    state_t                 state_q, state_d;
    logic [FRAME_LEN-1:0]   sr_q, sr_d;
    logic [FRAME_LEN-1:0]   frame;
    logic [3:0]             baud_q, baud_d;
    logic                   start_q, start_d;
    logic                   txrdy_q, txrdy_d;
    logic                   load_err_q, load_err_d;

    tx_frame_builder u_frame_builder (
        .din_i   (din_i),
        .eight_i (eight_i),
        .pen_i   (pen_i),
        .ohel_i  (ohel_i),
        .frame_o (frame)
    );

    // Next-state, shift register and registered-output decode.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        baud_d     = baud_q;
        load_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_i) begin
                    state_d = StSend;
                    sr_d    = frame;
                    baud_d  = baud_sel_i;
                end
            end
            StSend: begin
                load_err_d = load_i;
                // done has priority over a coincident btu.
                if (done_i) begin
                    state_d = StDrain;
                    sr_d    = {FRAME_LEN{IDLE_LEVEL}};
                end else if (btu_i) begin
                    sr_d = {IDLE_LEVEL, sr_q[FRAME_LEN-1:1]};
                end
            end
            StDrain: begin
                // One cycle with start low lets the timing unit clear done.
                load_err_d = load_i;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
                sr_d    = {FRAME_LEN{IDLE_LEVEL}};
            end
        endcase
        start_d = (state_d == StSend);
        txrdy_d = (state_d == StIdle);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            sr_q       <= {FRAME_LEN{IDLE_LEVEL}};
            baud_q     <= RST_BAUD;
            start_q    <= 1'b0;
            txrdy_q    <= 1'b1;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            baud_q     <= baud_d;
            start_q    <= start_d;
            txrdy_q    <= txrdy_d;
            load_err_q <= load_err_d;
        end
    end

    assign start_o    = start_q;
    assign baud_val_o = baud_q;
    assign tx_o       = sr_q[0];
    assign txrdy_o    = txrdy_q;
    assign load_err_o = load_err_q;

endmodule
